// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcodes and the issue-stage decode helper.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0] op;
    logic       use_imm;
    logic       is_br;
    logic       illegal;
  } dec_t;

  // Unsupported encodings fall back to ADD with the illegal flag set.
  function automatic dec_t decode_op(input logic [6:0] opcode,
                                     input logic [2:0] funct3,
                                     input logic [6:0] funct7);
    dec_t d;
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    d.is_br   = 1'b0;
    d.illegal = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     d.op = ALU_ADD;
            else if (funct7 == F7_ALT) d.op = ALU_SUB;
            else                       d.illegal = 1'b1;
          end
          3'b111:  d.op = ALU_AND;
          3'b110:  d.op = ALU_OR;
          3'b010:  d.op = ALU_SLT;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_I: begin
        d.use_imm = 1'b1;
        case (funct3)
          3'b000:  d.op = ALU_ADD;
          3'b111:  d.op = ALU_AND;
          3'b110:  d.op = ALU_OR;
          3'b010:  d.op = ALU_SLT;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LD, OP_ST: begin
        d.op      = ALU_ADD;
        d.use_imm = 1'b1;
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          d.op    = ALU_SUB;
          d.is_br = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.op      = ALU_ADD;
      d.use_imm = 1'b0;
      d.is_br   = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register. The main slot drives the outputs;
// the skid slot catches one entry while main is stalled, so in_ready is purely registered.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         xfer;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid && !skid_valid;
  assign xfer      = main_valid && out_ready;

  // Slot update: refill main from skid first, then from input; park in skid only when main is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || xfer) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_data <= in_data;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute stage feeding the ALU: decodes the op, selects operand b,
// and buffers the result in a 2-entry skid register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [XLEN-1:0]       in_rs1_val,
  input  logic [XLEN-1:0]       in_rs2_val,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [2:0]            alu_op,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_is_br,
  output logic                  out_illegal
);

  localparam int W = 2*XLEN + 3 + REG_ADDR_W + 2;

  dec_t            dec;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic [W-1:0]    in_data;
  logic [W-1:0]    out_data;

  // Input-side decode and operand selection; illegal entries carry zero operands.
  always_comb begin
    dec  = decode_op(in_opcode, in_funct3, in_funct7);
    a_in = '0;
    b_in = '0;
    if (!dec.illegal) begin
      a_in = in_rs1_val;
      b_in = dec.use_imm ? in_imm : in_rs2_val;
    end
  end

  assign in_data = {a_in, b_in, dec.op, in_rd, dec.is_br, dec.illegal};

  pipe_skid_reg #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {alu_a, alu_b, alu_op, out_rd, out_is_br, out_illegal} = out_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, skid backpressure, flush and reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_is_br, out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd),
    .out_is_br(out_is_br), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU used to confirm what the downstream unit would compute.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_funct3  = f3;
    in_funct7  = f7;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_imm     = imm;
    in_rd      = rd;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_rd = '0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_alu_a",     alu_a,              32'd0);
    rst_n = 1'b1;

    // R ADD
    drive(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd99, 5'd1);
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_op",    {29'd0, alu_op},    32'd2);
    chk("add_a",     alu_a,              32'd5);
    chk("add_b",     alu_b,              32'd7);
    chk("add_rd",    {27'd0, out_rd},    32'd1);

    // ORI
    drive(7'b0010011, 3'b110, 7'b1111111, 32'hF0, 32'h55, 32'h0F, 5'd3);
    step();
    chk("ori_op",  {29'd0, alu_op},    32'd1);
    chk("ori_b",   alu_b,              32'h0F);
    chk("ori_br",  {31'd0, out_is_br}, 32'd0);
    chk("ori_z",   alu_ref(alu_a, alu_b, alu_op), 32'hFF);

    // BEQ
    drive(7'b1100011, 3'b000, 7'b0000000, 32'h1234, 32'h1234, 32'h8, 5'd0);
    step();
    chk("beq_op", {29'd0, alu_op},    32'd6);
    chk("beq_br", {31'd0, out_is_br}, 32'd1);
    chk("beq_z",  alu_ref(alu_a, alu_b, alu_op), 32'd0);

    // Load: ADD with immediate
    drive(7'b0000011, 3'b010, 7'b0000000, 32'h100, 32'h777, 32'h20, 5'd9);
    step();
    in_valid = 1'b0;
    chk("ld_op", {29'd0, alu_op}, 32'd2);
    chk("ld_b",  alu_b,           32'h20);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three SUBs with out_ready low
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd1, 32'd0, 5'd1);
    step();
    chk("bp1_ready", {31'd0, in_ready}, 32'd1);
    chk("bp1_op",    {29'd0, alu_op},   32'd6);
    drive(7'b0110011, 3'b000, 7'b0100000, 32'd20, 32'd2, 32'd0, 5'd2);
    step();
    chk("bp2_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2_hold",  alu_a,             32'd10);
    drive(7'b0110011, 3'b000, 7'b0100000, 32'd30, 32'd3, 32'd0, 5'd3);
    step();
    chk("bp3_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3_hold",  alu_a,             32'd10);
    chk("bp3_rd",    {27'd0, out_rd},   32'd1);
    out_ready = 1'b1;
    step();
    chk("rel1_a",     alu_a,              32'd20);
    chk("rel1_valid", {31'd0, out_valid}, 32'd1);
    chk("rel1_ready", {31'd0, in_ready},  32'd1);
    step();
    in_valid = 1'b0;
    chk("rel2_a", alu_a,           32'd30);
    chk("rel2_b", alu_b,           32'd3);
    chk("rel2_rd", {27'd0, out_rd}, 32'd3);
    step();
    chk("rel3_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both slots full and an input pending
    out_ready = 1'b0;
    drive(7'b0110011, 3'b111, 7'b0000000, 32'd1, 32'd2, 32'd0, 5'd4);
    step();
    drive(7'b0110011, 3'b110, 7'b0000000, 32'd3, 32'd4, 32'd0, 5'd5);
    step();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    drive(7'b0110011, 3'b010, 7'b0000000, 32'd5, 32'd6, 32'd0, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_gone", {31'd0, out_valid}, 32'd0);

    // Illegal encoding still flows with zero operands
    drive(7'b1110011, 3'b000, 7'b0000000, 32'd99, 32'd88, 32'd77, 5'd7);
    step();
    chk("ill_flag",  {31'd0, out_illegal}, 32'd1);
    chk("ill_valid", {31'd0, out_valid},   32'd1);
    chk("ill_a",     alu_a,                32'd0);
    chk("ill_b",     alu_b,                32'd0);
    chk("ill_op",    {29'd0, alu_op},      32'd2);

    // Reset mid-stream with main and skid occupied
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 5'd8);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_valid", {31'd0, out_valid},   32'd0);
    chk("mrst_ready", {31'd0, in_ready},    32'd1);
    chk("mrst_ill",   {31'd0, out_illegal}, 32'd0);
    chk("mrst_rd",    {27'd0, out_rd},      32'd0);
    out_ready = 1'b1;
    step();
    chk("mrst_gone", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
